// File: rtl/norm_pkg.sv
// Shared types and helpers for the two-pass frame normalization controller.
package norm_pkg;

  // Controller phases: scan for min/max, then rewrite every pixel normalized.
  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SCAN_FIN,
    NORM,
    NORM_DRAIN,
    DONE
  } norm_state_e;

  // Full-scale pixel value for a given pixel width (2^width - 1).
  function automatic int unsigned pix_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/norm_scale.sv
// Combinational pixel scaler: (p - min) * PIX_MAX / range, truncating.
// A flat frame (range == 0) maps every pixel to zero.
module norm_scale
  import norm_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] pix_i,
  input  logic [DATA_WIDTH-1:0] min_i,
  input  logic [DATA_WIDTH-1:0] range_i,
  output logic [DATA_WIDTH-1:0] pix_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] PIX_MAX = PW'(pix_max(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] diff;
  logic [PW-1:0]         prod;

  // diff never exceeds range, so the quotient always fits in DATA_WIDTH bits.
  always_comb begin
    diff  = pix_i - min_i;
    prod  = PW'(diff) * PIX_MAX;
    pix_o = '0;
    if (range_i != '0) begin
      pix_o = DATA_WIDTH'(prod / PW'(range_i));
    end
  end

endmodule

// File: rtl/normalize_sequencer.sv
// Two-pass min/max normalization controller for a ROWS x COLS frame buffer.
// Pass 1 streams the frame to find min/max; pass 2 re-reads each pixel and
// writes the normalized value back two cycles after its read was issued.
module normalize_sequencer
  import norm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 128,
  parameter int COLS       = 128
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  output logic                                rd_en,
  output logic [$clog2(ROWS*COLS)-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]               rd_data,
  output logic                                wr_en,
  output logic [$clog2(ROWS*COLS)-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                busy,
  output logic                                done,
  output logic [DATA_WIDTH-1:0]               min_val,
  output logic [DATA_WIDTH-1:0]               max_val
);

  localparam int N      = ROWS * COLS;
  localparam int ADDR_W = $clog2(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  norm_state_e           state_q;
  logic                  rd_en_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic                  rvld_q;     // rd_data is valid this cycle
  logic                  rnorm_q;    // returning data belongs to the NORM pass
  logic [ADDR_W-1:0]     raddr_q;    // address of the data now on rd_data
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] min_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic                  drain_q;    // second drain cycle marker

  logic [DATA_WIDTH-1:0] pix_range;
  logic [DATA_WIDTH-1:0] norm_pix;

  // Range is stable for the whole NORM pass: min/max settle in SCAN_FIN.
  always_comb begin
    pix_range = max_q - min_q;
  end

  norm_scale #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_scale (
    .pix_i   (rd_data),
    .min_i   (min_q),
    .range_i (pix_range),
    .pix_o   (norm_pix)
  );

  // Phase sequencing, read-return tracking, min/max and write-back registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rvld_q    <= 1'b0;
      rnorm_q   <= 1'b0;
      raddr_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
      drain_q   <= 1'b0;
    end else if (abort) begin
      // Abort dominates start; in-flight reads are dropped, no further writes.
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rvld_q    <= 1'b0;
      rnorm_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe; tag it with its pass.
      rvld_q  <= rd_en_q;
      rnorm_q <= (state_q == NORM);
      raddr_q <= rd_addr_q;

      // NORM pass: scaled pixel lands on the write port two cycles after its read.
      wr_en_q <= rvld_q && rnorm_q;
      if (rvld_q && rnorm_q) begin
        wr_addr_q <= raddr_q;
        wr_data_q <= norm_pix;
      end

      // SCAN pass: fold returning pixels into the running extremes.
      if (rvld_q && !rnorm_q) begin
        if (rd_data < min_q) min_q <= rd_data;
        if (rd_data > max_q) max_q <= rd_data;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= SCAN;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            min_q     <= '1;
            max_q     <= '0;
          end
        end
        SCAN: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q   <= SCAN_FIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        SCAN_FIN: begin
          // Last scan pixel is absorbed this cycle; NORM reads start next.
          state_q   <= NORM;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
        NORM: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q   <= NORM_DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            drain_q   <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        NORM_DRAIN: begin
          // Two cycles let the final two writes leave the pipeline.
          if (drain_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    rd_en   = rd_en_q;
    rd_addr = rd_addr_q;
    wr_en   = wr_en_q;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    busy    = busy_q;
    done    = done_q;
    min_val = min_q;
    max_val = max_q;
  end

endmodule
